// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

   // Canonical no-op, used by the pipeline when it flushes decode.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding memory request at a time,
// buffers each returned word for decode and discards responses made stale by redirects.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

   fetch_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] redirect_aligned;
   logic                  kill, kill_next;
   logic                  buf_load;
   logic                  valid_next;
   logic                  req_valid_next;

   assign pc_inc           = pc + ADDR_WIDTH'(INSTR_BYTES);
   assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);
   assign imem_addr        = pc;

   // State, PC and output buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         kill           <= 1'b0;
         imem_req_valid <= 1'b0;
         instr_valid    <= 1'b0;
         instruction    <= '0;
         instr_pc       <= '0;
      end else begin
         state          <= state_next;
         pc             <= pc_next;
         kill           <= kill_next;
         imem_req_valid <= req_valid_next;
         instr_valid    <= valid_next;
         if (buf_load) begin
            instruction <= imem_rsp_data;
            instr_pc    <= pc;
         end
      end
   end

   // Next-state logic; a redirect overrides the normal transition of every state.
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      kill_next      = kill;
      buf_load       = 1'b0;
      valid_next     = instr_valid;
      req_valid_next = 1'b0;

      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            if (imem_req_ready) state_next = WAIT;
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (kill) begin
                  kill_next  = 1'b0;
                  state_next = REQ;
               end else begin
                  buf_load   = 1'b1;
                  valid_next = 1'b1;
                  pc_next    = pc_inc;
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (instr_ready) begin
               valid_next = 1'b0;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase

      if (redirect_valid) begin
         pc_next = redirect_aligned;
         case (state)
            REQ: begin
               // An accepted request still owes us a response that must be dropped.
               kill_next  = imem_req_ready;
               state_next = imem_req_ready ? WAIT : REQ;
            end
            WAIT: begin
               buf_load   = 1'b0;
               valid_next = 1'b0;
               kill_next  = !imem_rsp_valid;
               state_next = imem_rsp_valid ? REQ : WAIT;
            end
            HOLD: begin
               valid_next = 1'b0;
               state_next = REQ;
            end
            default: ;
         endcase
      end

      req_valid_next = (state_next == REQ);
   end

   // Memory must only answer while a request is outstanding.
   rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (state == WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked against a
// transaction-level model of which addresses are fetched and which words reach decode.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;

   fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: simulation time limit reached");
   end

   int n_pass  = 0;
   int n_total = 0;

   // stimulus controls
   bit          rnd_ready, rnd_iready, rnd_lat, rnd_redir;
   bit          iready_val;
   int          fixed_lat;
   bit          redir_now, redir_on_rsp;
   logic [31:0] redir_target;

   // memory model
   bit          mem_busy;
   int          mem_left;
   logic [31:0] mem_addr;

   // reference model: next address to fetch, in-flight request, decode buffer
   logic [31:0] m_pc;
   bit          m_inflight, m_stale;
   logic [31:0] m_infl_addr;
   bit          m_buf_valid;
   logic [31:0] m_buf_pc, m_buf_data;

   // observations
   int          cyc;
   bit          ev [4];
   logic [31:0] last_fire_addr, last_dlv_pc;
   logic [31:0] got_pc [$];
   int          got_cyc [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_pc = RST_PC;  m_inflight = 0; m_stale = 0; m_buf_valid = 0;
      mem_busy = 0;   mem_left = 0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check and update the model.
   task automatic tick();
      bit fire, rsp, dlv;
      cyc++;
      imem_req_ready = rnd_ready  ? ($urandom_range(0, 1) == 1) : 1'b1;
      instr_ready    = rnd_iready ? ($urandom_range(0, 1) == 1) : iready_val;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_busy) begin
         mem_left--;
         if (mem_left == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_busy       = 0;
         end
      end
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (redir_now || (redir_on_rsp && imem_rsp_valid)) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_target;
         redir_now      = 0;
         redir_on_rsp   = 0;
      end else if (rnd_redir && $urandom_range(0, 15) == 0) begin
         redirect_valid = 1'b1;
      end
      #1;
      fire = imem_req_valid && imem_req_ready;
      rsp  = imem_rsp_valid;
      dlv  = instr_valid && instr_ready;
      chk("instr_valid", 32'(instr_valid), 32'(m_buf_valid));
      if (m_buf_valid) begin
         chk("instr_pc", instr_pc, m_buf_pc);
         chk("instruction", instruction, m_buf_data);
      end
      if (imem_req_valid) chk("req_while_busy", 32'({m_inflight, m_buf_valid}), 32'h0);
      if (fire) begin
         chk("req_addr", imem_addr, m_pc);
         m_inflight     = 1; m_stale = 0; m_infl_addr = m_pc;
         mem_busy       = 1; mem_addr = imem_addr;
         mem_left       = rnd_lat ? int'($urandom_range(1, 4)) : fixed_lat;
         last_fire_addr = imem_addr;
      end
      if (dlv) begin
         got_pc.push_back(instr_pc);
         got_cyc.push_back(cyc);
         last_dlv_pc = instr_pc;
         m_buf_valid = 0;
      end
      if (rsp) begin
         if (!m_stale && !redirect_valid) begin
            m_buf_valid = 1;
            m_buf_pc    = m_infl_addr;
            m_buf_data  = mem_word(m_infl_addr);
            m_pc        = m_infl_addr + 32'd4;
         end
         m_inflight = 0;
      end
      if (redirect_valid) begin
         m_pc        = redirect_pc & ~32'h3;
         m_buf_valid = 0;
         if (m_inflight) m_stale = 1;
      end
      ev[0] = fire; ev[1] = rsp; ev[2] = dlv; ev[3] = instr_valid;
      @(negedge clk);
   endtask

   // Advance until event (0 fire, 1 response, 2 delivery, 3 instr_valid) or time out.
   task automatic wait_ev(input int which, input string tag);
      int n = 0;
      ev[which] = 0;
      while (!ev[which] && n < 40) begin
         tick();
         n++;
      end
      if (!ev[which]) chk({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_valid"},   32'(imem_req_valid), 32'h0);
      chk({tag, "_addr"},        imem_addr,           RST_PC);
      chk({tag, "_instr_valid"}, 32'(instr_valid),    32'h0);
      chk({tag, "_instruction"}, instruction,         32'h0);
      chk({tag, "_instr_pc"},    instr_pc,            32'h0);
   endtask

   initial begin
      logic [31:0] hold_pc;
      rst_n = 1'b0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
      redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
      rnd_ready = 0; rnd_iready = 0; rnd_lat = 0; rnd_redir = 0;
      iready_val = 1; fixed_lat = 1; redir_now = 0; redir_on_rsp = 0; redir_target = 0;
      cyc = 0; last_fire_addr = 0; last_dlv_pc = 0;
      model_reset();

      // reset values, then first request one cycle after release
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      #1 chk("idle_no_req", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      chk("first_req_valid", 32'(imem_req_valid), 32'h1);
      chk("first_req_addr", imem_addr, RST_PC);

      // latency 1, decode always ready: one instruction every third cycle
      cyc = 0;
      got_pc.delete(); got_cyc.delete();
      repeat (9) tick();
      chk("stream_count", 32'(got_pc.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < got_pc.size()) begin
            chk("stream_pc", got_pc[i], RST_PC + 32'(4 * i));
            chk("stream_cycle", 32'(got_cyc[i]), 32'(3 * (i + 1)));
         end
      end

      // decode stalls in HOLD: buffer stable, no new request, next fetch at instr_pc+4
      iready_val = 0;
      wait_ev(3, "hold_valid");
      hold_pc = m_buf_pc;
      repeat (5) begin
         chk("hold_no_req", 32'(imem_req_valid), 32'h0);
         chk("hold_pc_stable", instr_pc, hold_pc);
         tick();
      end
      iready_val = 1;
      wait_ev(0, "after_hold_fire");
      chk("after_hold_addr", last_fire_addr, hold_pc + 32'd4);

      // redirect during WAIT with latency 4: stale word dropped
      fixed_lat = 4;
      wait_ev(0, "c_fire");
      redir_now = 1; redir_target = 32'h0000_2003;
      tick();
      wait_ev(0, "c_refire");
      chk("redir_wait_addr", last_fire_addr, 32'h0000_2000);
      wait_ev(2, "c_deliver");
      chk("redir_wait_instr_pc", last_dlv_pc, 32'h0000_2000);

      // redirect coinciding with the response
      fixed_lat = 2;
      wait_ev(0, "d_fire");
      redir_on_rsp = 1; redir_target = 32'h0000_3000;
      wait_ev(1, "d_rsp");
      chk("redir_rsp_no_valid", 32'(instr_valid), 32'h0);
      wait_ev(0, "d_refire");
      chk("redir_rsp_addr", last_fire_addr, 32'h0000_3000);

      // PC wraps past the top of the address space
      redir_now = 1; redir_target = 32'hFFFF_FFFC;
      tick();
      wait_ev(0, "e_fire");
      chk("wrap_req_addr", last_fire_addr, 32'hFFFF_FFFC);
      wait_ev(2, "e_deliver");
      chk("wrap_instr_pc", last_dlv_pc, 32'hFFFF_FFFC);
      wait_ev(0, "e_next");
      chk("wrap_next_addr", last_fire_addr, 32'h0000_0000);

      // random traffic
      rnd_ready = 1; rnd_iready = 1; rnd_lat = 1; rnd_redir = 1;
      repeat (400) tick();
      rnd_ready = 0; rnd_iready = 0; rnd_lat = 0; rnd_redir = 0;
      iready_val = 1; fixed_lat = 5;

      // reset asserted while a request is in flight
      wait_ev(0, "g_fire");
      tick();
      rst_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      imem_rsp_valid = 0; redirect_valid = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_idle", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      chk("midrst_req_valid", 32'(imem_req_valid), 32'h1);
      chk("midrst_req_addr", imem_addr, RST_PC);
      wait_ev(2, "g_deliver");
      chk("midrst_instr_pc", last_dlv_pc, RST_PC);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the instruction word consumed by `control_unit`. It owns the program counter and issues requests to instruction memory over a valid/ready request channel, accepting responses that arrive with variable latency. Each returned word is held in a one-entry output register and offered to decode with a valid/ready handshake. Redirects from the branch/jump resolution logic retarget the PC and discard any stale in-flight response.

## Interface
- `DATA_WIDTH`, 32: instruction and memory data width.
- `ADDR_WIDTH`, 32: PC and memory address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  ADDR_WIDTH  fetch address, word aligned.
- `imem_rsp_valid`  in  1  response data valid; one response per accepted request, in order.
- `imem_rsp_data`  in  DATA_WIDTH  fetched word.
- `redirect_valid`  in  1  one-cycle PC redirect pulse.
- `redirect_pc`  in  ADDR_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1  `instruction`/`instr_pc` valid to decode.
- `instr_ready`  in  1  decode accepts the instruction.
- `instruction`  out  DATA_WIDTH  instruction word to `control_unit`.
- `instr_pc`  out  ADDR_WIDTH  address of `instruction`.

## Operation
- Registers: `pc`, `state`, `kill`, output buffer (`instruction`, `instr_pc`, `instr_valid`).
- At most one outstanding memory request. `imem_addr` equals `pc` and is held stable while `imem_req_valid` is high.
- FSM states:
  - **IDLE**: entered on reset. Moves to REQ on the first clock edge after reset is released.
  - **REQ**: `imem_req_valid` = 1. When `imem_req_ready` is high, go to WAIT.
  - **WAIT**: waits for `imem_rsp_valid`.
    - If `kill` = 1: drop the response, clear `kill`, go to REQ.
    - Otherwise: load `instruction` ← `imem_rsp_data` and `instr_pc` ← `pc`, set `instr_valid`, update `pc` ← `pc` + 4, go to HOLD.
  - **HOLD**: `instr_valid` = 1 and the buffer is held stable. When `instr_ready` is high, clear `instr_valid` and go to REQ.
- `pc` + 4 wraps modulo 2^ADDR_WIDTH.
- Redirect has priority over all other transitions:
  - All states: `pc` ← {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}.
  - REQ, request not accepted that cycle: stay in REQ. The new `pc` is presented the next cycle.
  - REQ, request accepted that cycle: the old-address request is in flight. Set `kill`, go to WAIT.
  - WAIT, no response that cycle: set `kill`, stay in WAIT.
  - WAIT, response that cycle: drop the response, go to REQ.
  - HOLD: clear `instr_valid`, go to REQ.
  - IDLE: `pc` is loaded, then the normal move to REQ.
- A decode handshake (`instr_valid` & `instr_ready`) in the same cycle as a redirect counts as delivered. Flushing that instruction downstream is the pipeline's responsibility.
- A response arriving in any state other than WAIT is a protocol error. It is ignored, and an assertion flags it in simulation.

## Timing
- Reset values:
  - `state` = IDLE, `pc` = `RESET_PC`, `kill` = 0.
  - `imem_req_valid` = 0, `imem_addr` = `RESET_PC`.
  - `instr_valid` = 0, `instruction` = 0, `instr_pc` = 0.
- The first request is visible one cycle after `rst_n` rises.
- Fetch latency: request accepted in cycle N; response in cycle N+L (L ≥ 1); `instr_valid` rises in cycle N+L+1.
- Peak throughput, with L = 1 and decode always ready: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect in cycle N: the new `pc` appears on `imem_addr` in cycle N+1, or after the killed response has drained.
- Asserting `rst_n` low mid-transaction returns every register to its reset value immediately. The in-flight response is then lost; the memory model is reset alongside.

## Structure
- Shared package `fetch_pkg` holds:
  - the `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD);
  - `INSTR_BYTES` = 4;
  - the `NOP_INSTR` = 32'h0000_0013 constant, for use by the pipeline's flush logic.
- No sub-module is required. The FSM, PC and output buffer fit in one module.

## Test plan
- Reset, `RESET_PC` = 0x100, memory latency 1, decode always ready → requests to 0x100, 0x104, 0x108; `instr_valid` every 3rd cycle with the matching `instr_pc`.
- Decode holds `instr_ready` = 0 for 5 cycles in HOLD → `instruction`/`instr_pc` stable, no new request, `pc` = `instr_pc` + 4.
- Redirect to 0x2003 while in WAIT with latency 4 → stale response dropped, next request to 0x2000, next `instr_pc` = 0x2000.
- Redirect in the same cycle as `imem_rsp_valid` → response dropped, no `instr_valid`, next request to the redirect target.
- `pc` = 0xFFFF_FFFC fetch → next request to 0x0000_0000.
- Pull `rst_n` low while in WAIT → all outputs at reset values immediately; after release, the request to `RESET_PC` appears one cycle later.
